// File: rtl/sa_fifo_ctrl_16x272_pkg.sv
// Shared sizing and types for the 16x272 systolic-array FIFO controller.
package sa_fifo_pkg;
  localparam int unsigned SA_FIFO_DEPTH = 16;
  localparam int unsigned SA_FIFO_AW    = 4;
  localparam int unsigned SA_FIFO_CW    = 5;
  localparam int unsigned SA_FIFO_DW    = 272;

  typedef logic [SA_FIFO_DW-1:0] sa_word_t;
  typedef logic [SA_FIFO_AW-1:0] sa_ptr_t;
  typedef logic [SA_FIFO_CW-1:0] sa_cnt_t;

  // Occupancy counter update: simultaneous inc and dec cancel out.
  function automatic sa_cnt_t sa_cnt_step(input sa_cnt_t c, input logic inc, input logic dec);
    case ({inc, dec})
      2'b10:   return c + sa_cnt_t'(1);
      2'b01:   return c - sa_cnt_t'(1);
      default: return c;
    endcase
  endfunction
endpackage

// File: rtl/sa_fifo_ctrl_16x272_if.sv
// Producer/consumer valid-ready handshake bundle for the 16x272 FIFO.
interface sa_fifo_ctrl_16x272_if;
  import sa_fifo_pkg::*;

  logic     in_pvld;
  logic     in_prdy;
  sa_word_t in_pd;
  logic     out_pvld;
  logic     out_prdy;
  sa_word_t out_pd;

  modport master (output in_pvld, in_pd, out_prdy,
                  input  in_prdy, out_pvld, out_pd);
  modport slave  (input  in_pvld, in_pd, out_prdy,
                  output in_prdy, out_pvld, out_pd);
endinterface

// File: rtl/sa_fifo_ctrl_16x272_ram.sv
// 16x272 register-file RAM: one write port, one read port with registered read address.
module sa_ram_rws_16x272
  import sa_fifo_pkg::*;
(
  input  logic        clk,
  input  sa_ptr_t     ra,
  input  logic        re,
  input  sa_ptr_t     wa,
  input  logic        we,
  input  sa_word_t    di,
  output sa_word_t    dout,
  input  logic [31:0] pwrbus_ram_pd
);
  sa_word_t mem [SA_FIFO_DEPTH];
  sa_ptr_t  ra_q;
  logic     unused_pwrbus;

  // Power-bus hook is carried for the macro wrapper; the behavioural array ignores it.
  assign unused_pwrbus = ^pwrbus_ram_pd;

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= di;
    if (re) ra_q    <= ra;
  end

  assign dout = mem[ra_q];
endmodule

// File: rtl/sa_fifo_ctrl_16x272.sv
// Valid/ready FIFO controller sequencing one 16x272 RAM; read data drives out_pd directly.
module sa_fifo_ctrl_16x272
  import sa_fifo_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  sa_fifo_ctrl_16x272_if.slave   io,
  output sa_cnt_t                fifo_count,
  output logic                   idle,
  input  logic [31:0]            pwrbus_ram_pd
);
  sa_ptr_t wr_ptr;
  sa_ptr_t rd_ptr;
  sa_cnt_t used;
  sa_cnt_t unread;
  logic    out_pvld_q;
  logic    in_prdy;
  logic    push;
  logic    pop;
  logic    rd;

  assign in_prdy = (used != sa_cnt_t'(SA_FIFO_DEPTH));
  assign push    = io.in_pvld & in_prdy;
  assign pop     = out_pvld_q & io.out_prdy;
  // A new read is only issued when the output slot is empty or being vacated,
  // so the RAM's held read address keeps out_pd stable during a stall.
  assign rd      = (unread != '0) & (~out_pvld_q | io.out_prdy);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      used       <= '0;
      unread     <= '0;
      out_pvld_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + sa_ptr_t'(1);
      if (rd)   rd_ptr <= rd_ptr + sa_ptr_t'(1);
      used   <= sa_cnt_step(used, push, pop);
      unread <= sa_cnt_step(unread, push, rd);
      if (rd)       out_pvld_q <= 1'b1;
      else if (pop) out_pvld_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (used <= sa_cnt_t'(SA_FIFO_DEPTH));
      assert (unread <= used);
      assert (!(pop && used == '0));
    end
  end

  assign io.in_prdy  = in_prdy;
  assign io.out_pvld = out_pvld_q;
  assign fifo_count  = used;
  assign idle        = (used == '0) & ~io.in_pvld;

  sa_ram_rws_16x272 u_ram (
    .clk           (clk),
    .ra            (rd_ptr),
    .re            (rd),
    .wa            (wr_ptr),
    .we            (push),
    .di            (io.in_pd),
    .dout          (io.out_pd),
    .pwrbus_ram_pd (pwrbus_ram_pd)
  );
endmodule
